// File: rtl/rot_vsplit_pkg.sv
// Shared types and sizing helpers for the rotation vector serializer.
package rot_vsplit_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    localparam int DEF_BW_XCOS = 10;
    localparam int DEF_N_ELEM  = 512;
    localparam int DEF_N_SEG   = 4;
    localparam int DEF_N_CH    = 4;

    function automatic int seg_w(input int n_elem, input int n_seg, input int bw);
        return (n_elem / n_seg) * bw;
    endfunction

    function automatic int seg_cnt_w(input int n_seg);
        return (n_seg > 1) ? $clog2(n_seg) : 1;
    endfunction

endpackage

// File: rtl/rot_vsplit_seg_sel.sv
// Combinational pick of one SEG_W slice per channel from a full vector set.
module rot_vsplit_seg_sel
    import rot_vsplit_pkg::*;
#(
    parameter int  BW_XCOS = DEF_BW_XCOS,
    parameter int  N_ELEM  = DEF_N_ELEM,
    parameter int  N_SEG   = DEF_N_SEG,
    parameter int  N_CH    = DEF_N_CH,
    localparam int SEG_W   = seg_w(N_ELEM, N_SEG, BW_XCOS),
    localparam int SCW     = seg_cnt_w(N_SEG),
    localparam int CH_W    = N_ELEM * BW_XCOS
) (
    input  logic [N_CH*CH_W-1:0]  i_buf,
    input  logic [SCW-1:0]        i_seg,
    output logic [N_CH*SEG_W-1:0] o_slice
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign o_slice[c*SEG_W +: SEG_W] = i_buf[c*CH_W + int'(i_seg)*SEG_W +: SEG_W];
    end

endmodule

// File: rtl/rotation_vec_serializer.sv
// Streams a captured N_CH-channel vector set as N_SEG registered beats, first beat one cycle after accept,
// holding outputs under out_ready stalls. ROT_VSPLIT_DBUF_EN adds a pending buffer for gapless back-to-back vectors.
module rotation_vec_serializer
    import rot_vsplit_pkg::*;
#(
    parameter int  BW_XCOS = DEF_BW_XCOS,
    parameter int  N_ELEM  = DEF_N_ELEM,
    parameter int  N_SEG   = DEF_N_SEG,
    parameter int  N_CH    = DEF_N_CH,
    localparam int SEG_W   = seg_w(N_ELEM, N_SEG, BW_XCOS),
    localparam int SCW     = seg_cnt_w(N_SEG),
    localparam int VEC_W   = N_CH * N_ELEM * BW_XCOS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VEC_W-1:0]       in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CH*SEG_W-1:0]  out_vec,
    output logic [SCW-1:0]         out_seg,
    output logic                   out_last,
    output logic                   busy
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SCW-1:0]          r_seg;
    logic [SCW-1:0]          w_seg_nxt;
    logic [VEC_W-1:0]        r_active;
    logic [N_CH*SEG_W-1:0]   r_out_vec;
    logic                    r_rdy_en;

    logic                    w_accept;
    logic                    w_beat;
    logic                    w_last_beat;
    logic                    w_cap_active;
    logic                    w_load_out;
    logic [VEC_W-1:0]        w_sel_buf;
    logic [SCW-1:0]          w_sel_idx;
    logic [N_CH*SEG_W-1:0]   w_slice;

`ifdef ROT_VSPLIT_DBUF_EN
    logic [VEC_W-1:0]        r_pend;
    logic                    r_pend_full;
    logic                    w_cap_pend;
    logic                    w_pend_pop;

    assign in_ready = r_rdy_en && !r_pend_full;
    assign busy     = (r_state == ST_STREAM) || r_pend_full;
`else
    assign in_ready = r_rdy_en && (r_state == ST_IDLE);
    assign busy     = (r_state == ST_STREAM);
`endif

    assign out_valid   = (r_state == ST_STREAM);
    assign out_seg     = r_seg;
    assign out_last    = out_valid && (r_seg == SCW'(N_SEG - 1));
    assign out_vec     = r_out_vec;
    assign w_accept    = in_valid && in_ready;
    assign w_beat      = out_valid && out_ready;
    assign w_last_beat = w_beat && (r_seg == SCW'(N_SEG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_seg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    // The registered out_vec is loaded with the slice that will be current next cycle,
    // so the selector looks at whichever buffer becomes active and at the next index.
    always_comb begin
        w_state_nxt  = r_state;
        w_seg_nxt    = r_seg;
        w_cap_active = 1'b0;
        w_load_out   = 1'b0;
        w_sel_buf    = r_active;
        w_sel_idx    = r_seg + SCW'(1);
`ifdef ROT_VSPLIT_DBUF_EN
        w_cap_pend   = 1'b0;
        w_pend_pop   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_STREAM;
                    w_seg_nxt    = '0;
                    w_cap_active = 1'b1;
                    w_load_out   = 1'b1;
                    w_sel_buf    = in_vec;
                    w_sel_idx    = '0;
                end
            end
            ST_STREAM: begin
                if (w_last_beat) begin
                    w_seg_nxt = '0;
                    w_sel_idx = '0;
`ifdef ROT_VSPLIT_DBUF_EN
                    if (r_pend_full) begin
                        w_pend_pop = 1'b1;
                        w_load_out = 1'b1;
                        w_sel_buf  = r_pend;
                    end else if (w_accept) begin
                        w_cap_active = 1'b1;
                        w_load_out   = 1'b1;
                        w_sel_buf    = in_vec;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else if (w_beat) begin
                    w_seg_nxt  = r_seg + SCW'(1);
                    w_load_out = 1'b1;
                end
`ifdef ROT_VSPLIT_DBUF_EN
                if (w_accept && !w_cap_active) begin
                    w_cap_pend = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    rot_vsplit_seg_sel #(
        .BW_XCOS (BW_XCOS),
        .N_ELEM  (N_ELEM),
        .N_SEG   (N_SEG),
        .N_CH    (N_CH)
    ) u_seg_sel (
        .i_buf   (w_sel_buf),
        .i_seg   (w_sel_idx),
        .o_slice (w_slice)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en  <= 1'b0;
            r_active  <= '0;
            r_out_vec <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_cap_active) begin
                r_active <= in_vec;
            end
`ifdef ROT_VSPLIT_DBUF_EN
            if (w_pend_pop) begin
                r_active <= r_pend;
            end
`endif
            if (w_load_out) begin
                r_out_vec <= w_slice;
            end
        end
    end

`ifdef ROT_VSPLIT_DBUF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_cap_pend) begin
            r_pend      <= in_vec;
            r_pend_full <= 1'b1;
        end else if (w_pend_pop) begin
            r_pend_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rotation_vec_serializer.sv
// Bench for rotation_vec_serializer: scoreboarded segment stream, stall stability, back-to-back, reset, alt params.
module tb_rotation_vec_serializer;

    localparam int BW    = 10;
    localparam int NE    = 512;
    localparam int NS    = 4;
    localparam int NC    = 4;
    localparam int EPS   = NE / NS;
    localparam int SEG_W = EPS * BW;
    localparam int OUT_W = NC * SEG_W;
    localparam int VEC_W = NC * NE * BW;
    localparam int SCW   = 2;

    localparam int BW2    = 12;
    localparam int NE2    = 64;
    localparam int NS2    = 8;
    localparam int NC2    = 2;
    localparam int EPS2   = NE2 / NS2;
    localparam int SEG_W2 = EPS2 * BW2;
    localparam int OUT_W2 = NC2 * SEG_W2;
    localparam int VEC_W2 = NC2 * NE2 * BW2;

    typedef struct {
        logic [SCW-1:0]   seg;
        logic [OUT_W-1:0] dat;
        logic             last;
    } beat_t;

    typedef struct {
        int         pat;
        logic [7:0] rdy;
        int         exp_cyc;
    } vec_rec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [VEC_W-1:0]   in_vec;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_vec;
    logic [SCW-1:0]     out_seg;
    logic               out_last;
    logic               busy;

    logic               in_valid_s;
    logic               in_ready_s;
    logic [VEC_W2-1:0]  in_vec_s;
    logic               out_valid_s;
    logic               out_ready_s;
    logic [OUT_W2-1:0]  out_vec_s;
    logic [2:0]         out_seg_s;
    logic               out_last_s;
    logic               busy_s;

    int    n_chk = 0;
    int    n_bad = 0;
    beat_t sb[$];
    beat_t mon_e;
    logic               stall_prev = 1'b0;
    logic [OUT_W-1:0]   stall_vec;
    logic [SCW-1:0]     stall_seg;
    logic               stall_last;
    vec_rec_t           tab[5];

    always #5 clk = ~clk;

    rotation_vec_serializer u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_seg   (out_seg),
        .out_last  (out_last),
        .busy      (busy)
    );

    rotation_vec_serializer #(
        .BW_XCOS (BW2),
        .N_ELEM  (NE2),
        .N_SEG   (NS2),
        .N_CH    (NC2)
    ) u_dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .in_vec    (in_vec_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .out_vec   (out_vec_s),
        .out_seg   (out_seg_s),
        .out_last  (out_last_s),
        .busy      (busy_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got low64=%h want low64=%h", nm, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [BW-1:0] elem(input int pat, input int c, input int k, input int seed);
        case (pat)
            0:       return BW'(c * NE + k);
            1:       return BW'(c * 37 + k * 11 + seed);
            2:       return '1;
            default: return BW'((k * k) ^ (c * 8) ^ seed);
        endcase
    endfunction

    function automatic logic [VEC_W-1:0] mk_vec(input int pat, input int seed);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NE; k++)
                v[(c * NE + k) * BW +: BW] = elem(pat, c, k, seed);
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] mk_seg(input int pat, input int seed, input int s);
        logic [OUT_W-1:0] d;
        d = '0;
        for (int c = 0; c < NC; c++)
            for (int j = 0; j < EPS; j++)
                d[c * SEG_W + j * BW +: BW] = elem(pat, c, s * EPS + j, seed);
        return d;
    endfunction

    task automatic push_exp(input int pat, input int seed);
        beat_t b;
        for (int s = 0; s < NS; s++) begin
            b.seg  = SCW'(s);
            b.dat  = mk_seg(pat, seed, s);
            b.last = (s == NS - 1);
            sb.push_back(b);
        end
    endtask

    task automatic scramble_in();
        for (int i = 0; i < VEC_W / 32; i++) in_vec[i * 32 +: 32] = $urandom();
    endtask

    // Monitor: every completed beat is popped from the scoreboard; stalled beats must hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_seg", 64'(out_seg), 64'(stall_seg));
                chk("stall_last", 64'(out_last), 64'(stall_last));
                chk_vec("stall_vec", out_vec, stall_vec);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL extra_beat: got seg %0d want no beat", out_seg);
                end else begin
                    mon_e = sb.pop_front();
                    chk("beat_seg", 64'(out_seg), 64'(mon_e.seg));
                    chk("beat_last", 64'(out_last), 64'(mon_e.last));
                    chk_vec("beat_data", out_vec, mon_e.dat);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_vec  = out_vec;
            stall_seg  = out_seg;
            stall_last = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic run_vec(input int pat, input logic [7:0] rdy, input int exp_cyc, input int seed);
        int cyc;
        push_exp(pat, seed);
        in_vec   = mk_vec(pat, seed);
        in_valid = 1'b1;
        chk("pre_valid", 64'(out_valid), 64'd0);
        chk("pre_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        scramble_in();
        out_ready = rdy[0];
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_seg", 64'(out_seg), 64'd0);
        cyc = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            if (!busy || cyc >= 40) break;
            out_ready = rdy[cyc % 8];
        end
        chk("drain_cycles", 64'(cyc), 64'(exp_cyc));
        chk("beats_left", 64'(sb.size()), 64'd0);
        sb.delete();
        out_ready = 1'b1;
    endtask

    task automatic back_to_back();
        logic [VEC_W-1:0] v2;
        int  n_acc, low, gap, exp_off, exp_low, exp_gap;
        int  acc_t[2];
        logic acc_now;
`ifdef ROT_VSPLIT_DBUF_EN
        exp_off = 1; exp_low = 3; exp_gap = 0;
`else
        exp_off = 5; exp_low = 8; exp_gap = 1;
`endif
        acc_t[0] = -1; acc_t[1] = -100;
        n_acc = 0; low = 0; gap = 0;
        push_exp(1, 11);
        push_exp(3, 22);
        v2        = mk_vec(3, 22);
        in_vec    = mk_vec(1, 11);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            acc_now = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc_now) begin
                acc_t[n_acc] = t;
                n_acc++;
                if (n_acc == 1) in_vec = v2;
                else begin
                    in_valid = 1'b0;
                    scramble_in();
                end
            end
            if (busy && !in_ready) low++;
            if (n_acc >= 1 && !out_valid && sb.size() > 0) gap++;
            if (n_acc == 2 && sb.size() == 0 && !busy) break;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 64'(n_acc), 64'd2);
        chk("b2b_second_offset", 64'(acc_t[1] - acc_t[0]), 64'(exp_off));
        chk("b2b_ready_low", 64'(low), 64'(exp_low));
        chk("b2b_gap", 64'(gap), 64'(exp_gap));
        chk("b2b_beats_left", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic reset_mid_stream();
        push_exp(1, 99);
        in_vec   = mk_vec(1, 99);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_seg", 64'(out_seg), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk_vec("rst_vec", out_vec, '0);
        chk("rst_beats_done", 64'(sb.size()), 64'd2);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready_after", 64'(in_ready), 64'd1);
        chk("rst_still_idle", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [BW2-1:0] elem_s(input int c, input int k);
        return BW2'(c * 64 + k * 5 + 3);
    endfunction

    task automatic small_params();
        logic [OUT_W2-1:0] d;
        for (int c = 0; c < NC2; c++)
            for (int k = 0; k < NE2; k++)
                in_vec_s[(c * NE2 + k) * BW2 +: BW2] = elem_s(c, k);
        chk("s_ready", 64'(in_ready_s), 64'd1);
        in_valid_s  = 1'b1;
        out_ready_s = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        for (int s = 0; s < NS2; s++) begin
            d = '0;
            for (int c = 0; c < NC2; c++)
                for (int j = 0; j < EPS2; j++)
                    d[c * SEG_W2 + j * BW2 +: BW2] = elem_s(c, s * EPS2 + j);
            chk("s_valid", 64'(out_valid_s), 64'd1);
            chk("s_seg", 64'(out_seg_s), 64'(s));
            chk("s_last", 64'(out_last_s), 64'(s == NS2 - 1));
            chk_vec("s_data", OUT_W'(out_vec_s), OUT_W'(d));
            @(posedge clk);
            #1;
        end
        chk("s_idle", 64'(out_valid_s), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tab[0] = '{pat: 0, rdy: 8'hFF, exp_cyc: 4};
        tab[1] = '{pat: 0, rdy: 8'h99, exp_cyc: 8};
        tab[2] = '{pat: 1, rdy: 8'hAA, exp_cyc: 8};
        tab[3] = '{pat: 2, rdy: 8'h33, exp_cyc: 6};
        tab[4] = '{pat: 3, rdy: 8'hFE, exp_cyc: 5};

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_vec      = '0;
        out_ready   = 1'b1;
        in_valid_s  = 1'b0;
        in_vec_s    = '0;
        out_ready_s = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd0);
        chk("reset_seg", 64'(out_seg), 64'd0);
        chk("reset_last", 64'(out_last), 64'd0);
        chk_vec("reset_vec", out_vec, '0);
        rst = 1'b0;
        chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 64'(in_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            run_vec(tab[i].pat, tab[i].rdy, tab[i].exp_cyc, i * 17 + 3);
            @(posedge clk);
            #1;
        end

        back_to_back();
        @(posedge clk);
        #1;
        reset_mid_stream();
        run_vec(0, 8'hFF, 4, 7);
        small_params();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/rotation_vec_serializer.md
ROTATION_VEC_SERIALIZER -- requirements
Module: rotation_vec_serializer

Interface
REQ-001 Parameter BW_XCOS, default 10, element width (5-bit integer, BW_XCOS-5 fraction).
REQ-002 Parameter N_ELEM, default 512, elements per channel vector.
REQ-003 Parameter N_SEG, default 4, segments per vector; power of two, 2..64, divides N_ELEM.
REQ-004 Parameter N_CH, default 4, channel count (cos_x, sin_x, cos_y, sin_y at defaults).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  in_vec holds a complete vector set.
REQ-008 in_ready  output  1  block can accept in_vec this cycle.
REQ-009 in_vec  input  N_CH*N_ELEM*BW_XCOS  channel c at bits [c*N_ELEM*BW_XCOS +: N_ELEM*BW_XCOS].
REQ-010 out_valid  output  1  out_vec/out_seg/out_last valid.
REQ-011 out_ready  input  1  downstream accepts the current segment.
REQ-012 out_vec  output  N_CH*SEG_W  SEG_W=(N_ELEM/N_SEG)*BW_XCOS; channel c at [c*SEG_W +: SEG_W].
REQ-013 out_seg  output  max(1,log2 N_SEG)  index of current segment.
REQ-014 out_last  output  1  high when out_seg==N_SEG-1 and out_valid.
REQ-015 busy  output  1  any vector held (active or pending).

Function
REQ-016 Accept occurs on a cycle with in_valid&&in_ready; in_vec is captured into the active buffer (or pending buffer, REQ-024).
REQ-017 out_valid SHALL rise exactly one cycle after an accept into an empty block, with out_seg=0.
REQ-018 Segment s of channel c SHALL equal in channel c bits [s*SEG_W +: SEG_W]; segments emitted in order 0..N_SEG-1.
REQ-019 A beat completes on out_valid&&out_ready; out_seg increments next cycle; out_vec, out_seg, out_last SHALL stay stable while out_valid&&!out_ready.
REQ-020 FSM states IDLE, STREAM: IDLE->STREAM on accept; STREAM->IDLE on completion of the last beat with no further vector available; otherwise STREAM continues at segment 0 of the next vector with no idle cycle.
REQ-021 out_valid SHALL be 0 in IDLE; out_vec holds its last value in IDLE (not cleared).
REQ-022 Segment counter wraps from N_SEG-1 to 0 only on last-beat completion.
REQ-023 in_vec changes while not accepted SHALL have no effect.

Reset
REQ-024 (see Configuration for pending buffer.)
REQ-025 On rst: state IDLE, segment counter 0, buffers and pending flag cleared, out_vec 0, out_valid 0, out_last 0, busy 0; in_ready 1 one cycle after rst deasserts... SHALL be 0 while rst high.
REQ-026 Reset mid-stream SHALL discard active and pending vectors; no further beats emitted for them.

Configuration
REQ-027 Macro ROT_VSPLIT_DBUF_EN defined: one pending buffer; in_ready=!pending_full; accepts during STREAM go to pending; at last-beat completion pending moves to active (seg 0, out_valid stays 1); if pending empty and an accept occurs in that same cycle, in_vec loads directly into active with out_valid staying 1.
REQ-028 Macro undefined: no pending buffer; in_ready=1 only in IDLE; consecutive vectors separated by at least one IDLE cycle of out_valid=0.

Structure
REQ-029 Package rot_vsplit_pkg SHALL hold the state enum, SEG_W and segment-counter-width functions, and default parameter constants.
REQ-030 Sub-module rot_vsplit_seg_sel: combinational selection of one SEG_W slice per channel from the active buffer given the segment index; out_vec SHALL be registered in the top.

Verification
REQ-031 Defaults, one vector, element k of channel c = (c*512+k) mod 1024, out_ready=1 -> 4 beats on consecutive cycles, first one cycle after accept, out_seg 0,1,2,3, out_last on beat 3 only, data per REQ-018.
REQ-032 out_ready toggled 1,0,0,1,... -> no beat lost or duplicated; outputs stable across stall cycles.
REQ-033 DBUF_EN, two vectors offered back-to-back, out_ready=1 -> 8 beats with no out_valid gap; in_ready low from second accept until first vector's last beat.
REQ-034 DBUF_EN undefined, same stimulus -> second accept only in IDLE; one out_valid=0 cycle between vectors.
REQ-035 rst asserted asynchronously after beat 1 -> out_valid, busy, out_seg, out_vec go 0 immediately; next vector starts at seg 0.
REQ-036 N_ELEM=64, N_SEG=8, N_CH=2, BW_XCOS=12 -> 8 beats, out_vec width 192, slicing per REQ-018.
